// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and constants for the serial-parallel multiplier
package spm_pkg;

    localparam int SPM_WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } spm_state_t;

endpackage

// File: rtl/spm_addsub.sv
// rtl/spm_addsub.sv - modulo-2^N adder/subtractor used by the multiplier accumulator
module spm_addsub #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] sum
);

    assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/param_spm.sv
// rtl/param_spm.sv - serial-parallel multiplier, one multiplier bit per clock, signed or unsigned
module param_spm
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    spm_state_t       state, next_state;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             mode_r;
    logic [W2-1:0]    ext_a;
    logic [W2-1:0]    sum;
    logic [W2-1:0]    acc_next;
    logic             load, step, last;

    always_comb begin
        ext_a = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: if (start) begin
                next_state = RUN;
                load       = 1'b1;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The sign bit of a two's-complement multiplier carries weight -2^(WIDTH-1).
    spm_addsub #(.N(W2)) u_addsub (
        .x   (acc),
        .y   (a_sh),
        .sub (mode_r & last),
        .sum (sum)
    );

    assign acc_next = b_sh[0] ? sum : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            mode_r  <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            acc    <= '0;
            a_sh   <= ext_a;
            b_sh   <= b;
            mode_r <= signed_mode;
            cnt    <= '0;
        end else if (step) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (last) product <= acc_next;
        end
    end

    // Status flags are registered from the next state so they never see inputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= (next_state == DONE);
            busy <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_param_spm.sv
// tb/tb_param_spm.sv - scoreboard bench for param_spm at WIDTH 8 and 16
module tb_param_spm;

    typedef struct {
        logic [31:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;
    logic        done8, busy8;

    logic        start16 = 1'b0, s16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] prod16;
    logic        done16, busy16;

    exp_t q8[$];
    exp_t q16[$];

    param_spm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(s8),
        .a(a8), .b(b8), .product(prod8), .done(done8), .busy(busy8)
    );

    param_spm #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(s16),
        .a(a16), .b(b16), .product(prod16), .done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
        longint sa, sb, r;
        sa = longint'(a);
        sb = longint'(b);
        if (s) begin
            if (a[w-1]) sa = sa - (64'sd1 <<< w);
            if (b[w-1]) sb = sb - (64'sd1 <<< w);
        end
        r = (sa * sb) & ((64'sd1 <<< (2 * w)) - 1);
        return r[31:0];
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("spurious_done8", 32'(done8), 32'd0);
            else begin
                exp_t e;
                e = q8.pop_front();
                chk("prod8", 32'(prod8), e.prod);
                chk("lat8", cyc, e.cyc);
            end
        end
        if (done16) begin
            if (q16.size() == 0) chk("spurious_done16", 32'(done16), 32'd0);
            else begin
                exp_t e;
                e = q16.pop_front();
                chk("prod16", prod16, e.prod);
                chk("lat16", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 300 && (busy8 || q8.size() != 0); i++) @(negedge clk);
        if (busy8 || q8.size() != 0) chk("timeout8", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle16();
        for (int i = 0; i < 300 && (busy16 || q16.size() != 0); i++) @(negedge clk);
        if (busy16 || q16.size() != 0) chk("timeout16", 32'(busy16), 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input bit push);
        wait_idle8();
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
        if (push) q8.push_back('{prod: 32'(exp), cyc: cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] exp);
        wait_idle16();
        a16 = a; b16 = b; s16 = s; start16 = 1'b1;
        q16.push_back('{prod: exp, cyc: cyc + 1 + 16});
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic        rs;

        repeat (2) @(negedge clk);
        chk("rst_prod8", 32'(prod8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_prod16", prod16, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'd10, 8'd15, 1'b1, 16'h0096, 1'b1);
        op8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1);
        op8(8'hF7, 8'hFC, 1'b1, 16'h0024, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);

        // Result must persist through idle and survive the next accepted start.
        wait_idle8();
        repeat (3) @(negedge clk);
        chk("hold_idle8", 32'(prod8), 32'h0000FE01);
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1);
        chk("hold_start8", 32'(prod8), 32'h0000FE01);
        wait_idle8();

        // Start held high: three back-to-back operations, operands scrambled mid-run.
        start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            a8 = ra; b8 = rb; s8 = rs;
            q8.push_back('{prod: mdl(8, 32'(ra), 32'(rb), rs), cyc: cyc + 1 + 8});
            for (int j = 0; j < 9; j++) begin
                @(negedge clk);
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            end
            if (i == 2) start8 = 1'b0;
            @(negedge clk);
        end
        wait_idle8();

        // Abort mid-run with reset; no done may follow.
        op8(8'd100, 8'd100, 1'b0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_prod8", 32'(prod8), 32'd0);
        chk("abort_busy8", 32'(busy8), 32'd0);
        chk("abort_done8", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_hold8", 32'(prod8), 32'd0);
        op8(8'd5, 8'hFD, 1'b1, 16'hFFF1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            op8(ra, rb, rs, 16'(mdl(8, 32'(ra), 32'(rb), rs)), 1'b1);
        end
        wait_idle8();

        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        op16(16'd3, 16'hFFFF, 1'b1, 32'hFFFFFFFD);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        for (int i = 0; i < 4; i++) begin
            wa = 16'($urandom); wb = 16'($urandom); rs = 1'($urandom);
            op16(wa, wb, rs, mdl(16, 32'(wa), 32'(wb), rs));
        end
        wait_idle16();

        chk("q8_drained", q8.size(), 32'd0);
        chk("q16_drained", q16.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
